// File: rtl/card_board.sv
// Card playfield for a pair-matching game: shuffled pair colours, per-card state,
// click-to-card hit testing and a registered read port for the renderer.
module card_board #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned ORIGIN_X  = 112,
    parameter int unsigned ORIGIN_Y  = 84,
    parameter int unsigned CARD_W    = 160,
    parameter int unsigned CARD_H    = 160,
    parameter int unsigned GAP       = 32,
    parameter logic [11:0] COLOR0    = 12'hF00,
    parameter logic [11:0] COLOR1    = 12'h0F0,
    parameter logic [11:0] COLOR2    = 12'h00F,
    parameter logic [11:0] COLOR3    = 12'hFF0,
    parameter logic [11:0] COLOR4    = 12'hF0F,
    parameter logic [11:0] COLOR5    = 12'h0FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        compute_colors_en,
    output logic        compute_done,
    input  logic        write_card_en,
    input  logic [1:0]  write_card_state,
    input  logic [3:0]  write_card_address,
    input  logic        wait_for_click_en,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic        card_pressed,
    output logic [3:0]  card_clicked_address,
    output logic [11:0] card_clicked_color,
    input  logic [3:0]  rd_address,
    output logic [1:0]  rd_state,
    output logic [11:0] rd_color
);

    localparam int unsigned NumCards = 12;
    localparam int unsigned PitchX   = CARD_W + GAP;
    localparam int unsigned PitchY   = CARD_H + GAP;
    localparam logic [1:0]  StCovered = 2'b01;

    typedef enum logic [2:0] {StIdle, StInit, StSwap, StDone, StHold} fsm_e;

    logic [11:0] pair_color [6];
    assign pair_color[0] = COLOR0;
    assign pair_color[1] = COLOR1;
    assign pair_color[2] = COLOR2;
    assign pair_color[3] = COLOR3;
    assign pair_color[4] = COLOR4;
    assign pair_color[5] = COLOR5;

    fsm_e        fsm_q;
    logic [15:0] lfsr_q;
    logic [3:0]  swap_i_q;
    logic [1:0]  state_q [NumCards];
    logic [11:0] color_q [NumCards];

    logic [3:0]  swap_j;
    assign swap_j = lfsr_q[3:0];

    // Galois form, taps 16,14,13,11 -> feedback mask 0xB400
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= StIdle;
            swap_i_q     <= 4'd0;
            compute_done <= 1'b0;
            for (int k = 0; k < NumCards; k++) begin
                state_q[k] <= 2'b00;
                color_q[k] <= 12'h000;
            end
        end else begin
            compute_done <= 1'b0;
            unique case (fsm_q)
                StIdle: begin
                    if (compute_colors_en) fsm_q <= StInit;
                end
                StInit: begin
                    if (!compute_colors_en) begin
                        fsm_q <= StIdle;
                    end else begin
                        for (int k = 0; k < NumCards; k++) begin
                            color_q[k] <= pair_color[k >> 1];
                            state_q[k] <= StCovered;
                        end
                        swap_i_q <= 4'd11;
                        fsm_q    <= StSwap;
                    end
                end
                StSwap: begin
                    if (!compute_colors_en) begin
                        fsm_q <= StIdle;
                    end else if (swap_j <= swap_i_q) begin
                        color_q[swap_i_q] <= color_q[swap_j];
                        color_q[swap_j]   <= color_q[swap_i_q];
                        swap_i_q          <= swap_i_q - 4'd1;
                        if (swap_i_q == 4'd1) fsm_q <= StDone;
                    end
                end
                StDone: begin
                    compute_done <= 1'b1;
                    fsm_q        <= StHold;
                end
                StHold: begin
                    if (!compute_colors_en) fsm_q <= StIdle;
                end
                default: fsm_q <= StIdle;
            endcase

            // The shuffle owns the card array while it runs
            if (write_card_en && (write_card_address < 4'd12) && (write_card_state != 2'b00)
                && (fsm_q != StInit) && (fsm_q != StSwap)) begin
                state_q[write_card_address] <= write_card_state;
            end
        end
    end

    logic [3:0] col_hit;
    logic [2:0] row_hit;
    logic [1:0] col_idx;
    logic [1:0] row_idx;
    logic       hit;

    always_comb begin
        col_hit = '0;
        row_hit = '0;
        col_idx = 2'd0;
        row_idx = 2'd0;
        for (int c = 0; c < 4; c++) begin
            col_hit[c] = ({20'd0, mouse_xpos} >= ORIGIN_X + c * PitchX) &&
                         ({20'd0, mouse_xpos} <  ORIGIN_X + c * PitchX + CARD_W);
            if (col_hit[c]) col_idx = 2'(c);
        end
        for (int r = 0; r < 3; r++) begin
            row_hit[r] = ({20'd0, mouse_ypos} >= ORIGIN_Y + r * PitchY) &&
                         ({20'd0, mouse_ypos} <  ORIGIN_Y + r * PitchY + CARD_H);
            if (row_hit[r]) row_idx = 2'(r);
        end
        hit = (|col_hit) && (|row_hit);
    end

    logic       mouse_prev_q;
    logic       armed_q;
    logic       s1_valid_q;
    logic       s1_hit_q;
    logic [3:0] s1_idx_q;
    logic       click;
    logic       press;

    assign click = mouse_left && !mouse_prev_q && wait_for_click_en && armed_q;
    // State is sampled before any write landing on the same edge
    assign press = s1_valid_q && s1_hit_q && wait_for_click_en && armed_q &&
                   (state_q[s1_idx_q] == StCovered);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mouse_prev_q         <= 1'b0;
            armed_q              <= 1'b1;
            s1_valid_q           <= 1'b0;
            s1_hit_q             <= 1'b0;
            s1_idx_q             <= 4'd0;
            card_pressed         <= 1'b0;
            card_clicked_address <= 4'd0;
            card_clicked_color   <= 12'h000;
        end else begin
            mouse_prev_q <= mouse_left;
            s1_valid_q   <= click;
            s1_hit_q     <= hit;
            s1_idx_q     <= {row_idx, col_idx};
            card_pressed <= press;
            if (press) begin
                card_clicked_address <= s1_idx_q;
                card_clicked_color   <= color_q[s1_idx_q];
            end
            if (!wait_for_click_en) begin
                armed_q <= 1'b1;
            end else if (press) begin
                armed_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= 2'b00;
            rd_color <= 12'h000;
        end else if (rd_address < 4'd12) begin
            rd_state <= state_q[rd_address];
            rd_color <= color_q[rd_address];
        end else begin
            rd_state <= 2'b00;
            rd_color <= 12'h000;
        end
    end

endmodule

// File: tb/tb_card_board.sv
// Self-checking bench for card_board: directed scenarios plus a randomized click/write
// phase checked against a behavioural playfield model.
module tb_card_board;

    localparam int OX = 112;
    localparam int OY = 84;
    localparam int CW = 160;
    localparam int CH = 160;
    localparam int GP = 32;

    logic        clk;
    logic        rst_n;
    logic        compute_colors_en;
    logic        compute_done;
    logic        write_card_en;
    logic [1:0]  write_card_state;
    logic [3:0]  write_card_address;
    logic        wait_for_click_en;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        card_pressed;
    logic [3:0]  card_clicked_address;
    logic [11:0] card_clicked_color;
    logic [3:0]  rd_address;
    logic [1:0]  rd_state;
    logic [11:0] rd_color;

    card_board dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .compute_colors_en    (compute_colors_en),
        .compute_done         (compute_done),
        .write_card_en        (write_card_en),
        .write_card_state     (write_card_state),
        .write_card_address   (write_card_address),
        .wait_for_click_en    (wait_for_click_en),
        .mouse_left           (mouse_left),
        .mouse_xpos           (mouse_xpos),
        .mouse_ypos           (mouse_ypos),
        .card_pressed         (card_pressed),
        .card_clicked_address (card_clicked_address),
        .card_clicked_color   (card_clicked_color),
        .rd_address           (rd_address),
        .rd_state             (rd_state),
        .rd_color             (rd_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  m_state [12];
    logic [11:0] m_color [12];
    bit          m_armed;
    logic [11:0] pair_colors [6] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Card index under the pointer, or -1 for gaps and outside the grid
    function automatic int hit_idx(input int x, input int y);
        int c, r;
        if (x < OX || y < OY) return -1;
        c = (x - OX) / (CW + GP);
        r = (y - OY) / (CH + GP);
        if (c > 3 || r > 2) return -1;
        if ((x - OX) % (CW + GP) >= CW || (y - OY) % (CH + GP) >= CH) return -1;
        return r * 4 + c;
    endfunction

    task automatic read_card(input int a, output logic [1:0] s, output logic [11:0] c);
        rd_address = 4'(a);
        tick;
        s = rd_state;
        c = rd_color;
    endtask

    task automatic write_card(input int a, input int st);
        logic [1:0]  s;
        logic [11:0] c;
        int          ra;
        write_card_en      = 1'b1;
        write_card_address = 4'(a);
        write_card_state   = 2'(st);
        tick;
        write_card_en = 1'b0;
        if (a < 12 && st != 0) m_state[a] = 2'(st);
        ra = (a < 12) ? a : a - 12;
        read_card(ra, s, c);
        check($sformatf("write a=%0d st=%0d rd_state[%0d]", a, st, ra), 32'(s), 32'(m_state[ra]));
    endtask

    task automatic run_shuffle(input string tag);
        int first = -1;
        int pulses = 0;
        compute_colors_en = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            tick;
            if (compute_done) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        check({tag, " done pulses"}, 32'(pulses), 32'd1);
        check({tag, " done latency in 11..200"}, 32'(first >= 11 && first <= 200), 32'd1);
    endtask

    task automatic snapshot(input string tag);
        int          cnt [6];
        logic [1:0]  s;
        logic [11:0] c;
        for (int n = 0; n < 6; n++) cnt[n] = 0;
        for (int k = 0; k < 12; k++) begin
            read_card(k, s, c);
            check($sformatf("%s state[%0d]", tag, k), 32'(s), 32'd1);
            m_state[k] = 2'd1;
            m_color[k] = c;
            for (int n = 0; n < 6; n++) if (c == pair_colors[n]) cnt[n]++;
        end
        for (int n = 0; n < 6; n++)
            check($sformatf("%s colour %0d count", tag, n), 32'(cnt[n]), 32'd2);
    endtask

    task automatic click(input int x, input int y, input string tag);
        int idx;
        bit exp;
        idx = hit_idx(x, y);
        exp = m_armed && wait_for_click_en && idx >= 0;
        if (exp) exp = (m_state[idx] == 2'd1);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b1;
        tick;
        check({tag, " pressed @+1"}, 32'(card_pressed), 32'd0);
        tick;
        check({tag, " pressed @+2"}, 32'(card_pressed), 32'(exp));
        if (exp) begin
            check({tag, " address"}, 32'(card_clicked_address), 32'(idx));
            check({tag, " colour"}, 32'(card_clicked_color), 32'(m_color[idx]));
            m_armed = 1'b0;
        end
        mouse_left = 1'b0;
        tick;
        check({tag, " pressed @+3"}, 32'(card_pressed), 32'd0);
    endtask

    task automatic rearm;
        wait_for_click_en = 1'b0;
        tick;
        m_armed = 1'b1;
        wait_for_click_en = 1'b1;
        tick;
    endtask

    initial begin
        logic [1:0]  s;
        logic [11:0] c;
        int          k;
        rst_n = 1'b0;
        compute_colors_en = 1'b0;
        write_card_en = 1'b0;
        write_card_state = 2'd0;
        write_card_address = 4'd0;
        wait_for_click_en = 1'b0;
        mouse_left = 1'b0;
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        rd_address = 4'd0;
        for (int i = 0; i < 12; i++) begin
            m_state[i] = 2'd0;
            m_color[i] = 12'h000;
        end
        m_armed = 1'b1;
        #23;
        check("reset compute_done", 32'(compute_done), 32'd0);
        check("reset card_pressed", 32'(card_pressed), 32'd0);
        check("reset clicked_address", 32'(card_clicked_address), 32'd0);
        check("reset clicked_color", 32'(card_clicked_color), 32'd0);
        check("reset rd_state", 32'(rd_state), 32'd0);
        check("reset rd_color", 32'(rd_color), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        run_shuffle("shuffle1");
        snapshot("shuffle1");
        compute_colors_en = 1'b0;
        tick;
        read_card(14, s, c);
        check("rd addr 14 state", 32'(s), 32'd0);
        check("rd addr 14 colour", 32'(c), 32'd0);

        wait_for_click_en = 1'b1;
        tick;
        click(OX + CW + GP + 5, OY + 5, "card1");
        check("card1 address literal", 32'(card_clicked_address), 32'd1);
        click(OX + CW + GP + 5, OY + 5, "card1 again unarmed");
        rearm;

        write_card(5, 3);
        click(OX + (CW + GP) + 80, OY + (CH + GP) + 80, "card5 discovered");
        write_card(5, 2);
        write_card(5, 1);
        click(OX + (CW + GP) + 80, OY + (CH + GP) + 80, "card5 covered");
        check("card5 address literal", 32'(card_clicked_address), 32'd5);
        rearm;

        click(OX + CW + 1, OY + 5, "gap x");
        click(OX + 5, 700, "outside y");
        write_card(13, 1);
        write_card(2, 0);

        // Stage-2 press and a state write on the same edge
        mouse_xpos = 12'(OX + 3 * (CW + GP) + 10);
        mouse_ypos = 12'(OY + 10);
        mouse_left = 1'b1;
        tick;
        write_card_en = 1'b1;
        write_card_address = 4'd3;
        write_card_state = 2'd3;
        tick;
        write_card_en = 1'b0;
        check("same-cycle press", 32'(card_pressed), 32'd1);
        check("same-cycle address", 32'(card_clicked_address), 32'd3);
        check("same-cycle colour", 32'(card_clicked_color), 32'(m_color[3]));
        m_state[3] = 2'd3;
        m_armed = 1'b0;
        mouse_left = 1'b0;
        read_card(3, s, c);
        check("same-cycle rd_state[3]", 32'(s), 32'd3);
        rearm;

        // Asynchronous reset in the middle of a shuffle
        compute_colors_en = 1'b1;
        tick;
        tick;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst compute_done", 32'(compute_done), 32'd0);
        check("async rst card_pressed", 32'(card_pressed), 32'd0);
        check("async rst clicked_address", 32'(card_clicked_address), 32'd0);
        check("async rst clicked_color", 32'(card_clicked_color), 32'd0);
        check("async rst rd_state", 32'(rd_state), 32'd0);
        check("async rst rd_color", 32'(rd_color), 32'd0);
        compute_colors_en = 1'b0;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        m_armed = 1'b1;
        for (int i = 0; i < 12; i++) begin
            read_card(i, s, c);
            check($sformatf("post-reset state[%0d]", i), 32'(s), 32'd0);
        end
        run_shuffle("shuffle2");
        snapshot("shuffle2");
        compute_colors_en = 1'b0;
        tick;
        rearm;

        for (int it = 0; it < 80; it++) begin
            k = int'($urandom_range(0, 9));
            if (k <= 2) begin
                write_card(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            end else if (k == 3) begin
                rearm;
            end else if ($urandom_range(0, 2) != 0) begin
                k = int'($urandom_range(0, 11));
                click(OX + (k % 4) * (CW + GP) + int'($urandom_range(0, CW - 1)),
                      OY + (k / 4) * (CH + GP) + int'($urandom_range(0, CH - 1)),
                      $sformatf("rand card %0d", k));
            end else begin
                click(int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)), "rand point");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
